// File: rtl/piso_stream.sv
// piso_stream: parallel-in / serial-out shift register with a valid/ready
// load handshake, selectable bit order and an external bit-rate strobe.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   parallel_in   WIDTH-bit word, sampled when in_valid && in_ready
//   in_valid      upstream has a word on parallel_in
//   in_ready      block accepts parallel_in this cycle (combinational)
//   shift_en      bit-rate strobe; retires one bit per high cycle in SHIFT
//   serial_out    current serial bit (registered), IDLE_LEVEL when idle
//   serial_valid  serial_out carries a data bit
//   done          one-cycle pulse after the last bit of a word retires
module piso_stream #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             done
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;     // bits already retired from the current word

    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] shifted;

    // The last bit retires on this edge, so the slot is free for a new word
    // at the very same edge: this is what gives gap-free back-to-back words.
    assign last_bit = (state == SHIFT) && shift_en && (cnt == LAST);
    assign in_ready = (state == IDLE) || last_bit;
    assign accept   = in_valid && in_ready;
    assign shifted  = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // serial_out is registered, so it is loaded with the bit that will sit
    // at the output end of the register after this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shreg        <= '0;
            cnt          <= '0;
            done         <= 1'b0;
            serial_valid <= 1'b0;
            serial_out   <= IDLE_LEVEL;
        end else begin
            done <= last_bit;
            if (accept) begin
                state        <= SHIFT;
                shreg        <= parallel_in;
                cnt          <= '0;
                serial_valid <= 1'b1;
                serial_out   <= out_bit(parallel_in);
            end else if (last_bit) begin
                state        <= IDLE;
                shreg        <= '0;
                cnt          <= '0;
                serial_valid <= 1'b0;
                serial_out   <= IDLE_LEVEL;
            end else if ((state == SHIFT) && shift_en) begin
                shreg      <= shifted;
                cnt        <= cnt + 1'b1;
                serial_out <= out_bit(shifted);
            end
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: three instances (4-bit MSB-first idle-0, 4-bit
// LSB-first idle-1, 8-bit MSB-first idle-0) share clock, reset and strobe.
// A word/bit-index model predicts every output each cycle; directed
// sequences pin the model with hand-computed bit streams.
module tb_piso_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       se;
    logic [2:0] iv;
    logic [7:0] pin [3];
    logic [2:0] rdy, so, sv, dn;

    always #5 clk = ~clk;

    piso_stream #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .reset(rst), .parallel_in(pin[0][3:0]), .in_valid(iv[0]),
        .in_ready(rdy[0]), .shift_en(se), .serial_out(so[0]),
        .serial_valid(sv[0]), .done(dn[0]));

    piso_stream #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_b (
        .clk(clk), .reset(rst), .parallel_in(pin[1][3:0]), .in_valid(iv[1]),
        .in_ready(rdy[1]), .shift_en(se), .serial_out(so[1]),
        .serial_valid(sv[1]), .done(dn[1]));

    piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_c (
        .clk(clk), .reset(rst), .parallel_in(pin[2]), .in_valid(iv[2]),
        .in_ready(rdy[2]), .shift_en(se), .serial_out(so[2]),
        .serial_valid(sv[2]), .done(dn[2]));

    localparam int WK [3] = '{4, 4, 8};
    localparam bit MK [3] = '{1'b1, 1'b0, 1'b1};
    localparam bit IK [3] = '{1'b0, 1'b1, 1'b0};

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    // Model: the word being sent, how many of its bits are gone, busy flag.
    bit       busy     [3];
    bit [7:0] word     [3];
    int       pos      [3];
    bit       mdone    [3];
    bit       acc_last [3];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    function automatic bit exp_bit(input int k);
        return MK[k] ? word[k][WK[k]-1-pos[k]] : word[k][pos[k]];
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) begin
            busy[k] = 0; word[k] = 0; pos[k] = 0; mdone[k] = 0; acc_last[k] = 0;
        end
    end

    // Compare, then advance the model by the edge that follows.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit mrdy;
            bit acc;
            mrdy = !busy[k] || (se && pos[k] == WK[k] - 1);
            if (chk_on) begin
                check($sformatf("serial_valid[%0d]", k), sv[k], busy[k]);
                check($sformatf("serial_out[%0d]", k), so[k], busy[k] ? exp_bit(k) : IK[k]);
                check($sformatf("done[%0d]", k), dn[k], mdone[k]);
                check($sformatf("in_ready[%0d]", k), rdy[k], mrdy);
            end
            if (rst) begin
                busy[k] = 0; pos[k] = 0; mdone[k] = 0; acc_last[k] = 0;
            end else begin
                acc = iv[k] && mrdy;
                mdone[k] = 0;
                if (busy[k] && se) begin
                    if (pos[k] == WK[k] - 1) begin
                        mdone[k] = 1; busy[k] = 0;
                    end else pos[k]++;
                end
                if (acc) begin
                    busy[k] = 1; word[k] = pin[k]; pos[k] = 0;
                end
                acc_last[k] = acc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] sa, sb, s5;
        logic [7:0] s8, wa5, w3c;
        sa = 4'b1101; sb = 4'b1011; s5 = 4'b1001; s8 = 8'b1101_0110;
        wa5 = 8'hA5; w3c = 8'h3C;

        // 1: reset with valid and strobe active
        rst = 1; se = 1; iv = 3'b111;
        pin[0] = 8'h0F; pin[1] = 8'h0F; pin[2] = 8'hFF;
        step();
        chk_on = 1;
        step();
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_sv", sv[k], 0);
            check("rst_so", so[k], IK[k]);
            check("rst_done", dn[k], 0);
            check("rst_ready", rdy[k], 1);
        end
        rst = 0; iv = 3'b000;
        step();
        check("no_accept_in_reset", sv[0], 0);

        // 2/3: single 4'b1101 word, MSB-first and LSB-first/idle-1
        pin[0] = 8'h0D; pin[1] = 8'h0D; iv = 3'b011;
        #1;
        check("idle1_before", so[1], 1);
        step();
        iv = 3'b000;
        for (int i = 0; i < 4; i++) begin
            check("msb_bit", so[0], sa[3-i]);
            check("lsb_bit", so[1], sb[3-i]);
            check("word_sv", sv[0], 1);
            step();
        end
        check("single_done", dn[0], 1);
        check("single_sv_low", sv[0], 0);
        check("idle1_after", so[1], 1);
        step();
        check("done_one_cycle", dn[0], 0);

        // 4: back-to-back words, no gap
        pin[0] = 8'h0D; iv[0] = 1;
        #1;
        check("b2b_ready_idle", rdy[0], 1);
        step();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) pin[0] = 8'h06;
            if (i == 4) iv[0] = 0;
            #1;
            check("b2b_bit", so[0], s8[7-i]);
            check("b2b_sv", sv[0], 1);
            check("b2b_ready", rdy[0], (i == 3 || i == 7));
            check("b2b_done", dn[0], (i == 4));
            step();
        end
        check("b2b_done2", dn[0], 1);
        check("b2b_end_sv", sv[0], 0);

        // 5: strobe every other cycle, each bit held two cycles
        pin[0] = 8'h09; iv[0] = 1; se = 0;
        step();
        for (int i = 0; i < 8; i++) begin
            se = (i % 2 == 1);
            if (i == 6) iv[0] = 0;
            #1;
            check("slow_bit", so[0], s5[3-i/2]);
            check("slow_ready", rdy[0], (i == 7));
            check("slow_sv", sv[0], 1);
            step();
        end
        check("slow_done", dn[0], 1);

        // 6: reset mid-word, then a clean word
        se = 1; pin[2] = 8'hA5; iv[2] = 1;
        step();
        iv[2] = 0;
        for (int i = 0; i < 3; i++) begin
            check("a5_bit", so[2], wa5[7-i]);
            step();
        end
        rst = 1;
        step();
        rst = 0;
        check("midrst_sv", sv[2], 0);
        check("midrst_so", so[2], 0);
        check("midrst_done", dn[2], 0);
        step();
        check("midrst_no_done", dn[2], 0);
        pin[2] = 8'h3C; iv[2] = 1;
        step();
        iv[2] = 0;
        for (int i = 0; i < 8; i++) begin
            check("3c_bit", so[2], w3c[7-i]);
            check("3c_sv", sv[2], 1);
            step();
        end
        check("3c_done", dn[2], 1);

        // Random traffic; the per-cycle model comparison does the checking.
        for (int n = 0; n < 4000; n++) begin
            step();
            se  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 3; k++) begin
                if (!(iv[k] && !acc_last[k])) begin
                    iv[k]  = ($urandom_range(0, 2) != 0);
                    pin[k] = 8'($urandom) & ((WK[k] == 8) ? 8'hFF : 8'h0F);
                end
            end
        end
        rst = 0; iv = 3'b000;
        step();
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
